// File: rtl/chg_log_pkg.sv
// chg_log_monitor shared types and constants.
// CHG_LOG_TIMESTAMP_EN adds a timestamp field to each log entry.
package chg_log_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_SAT = 16'hFFFF;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_TS_W  = 32;

`ifdef CHG_LOG_TIMESTAMP_EN
  typedef struct packed {
    logic [DEF_TS_W-1:0]  ts;
    logic [DEF_WIDTH-1:0] data;
  } chg_entry_t;
`else
  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
  } chg_entry_t;
`endif

  function automatic logic [DROP_CNT_W-1:0] sat_inc(
    input logic [DROP_CNT_W-1:0] v
  );
    return (v == DROP_SAT) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/chg_log_fifo.sv
// First-word-fall-through FIFO for chg_log_monitor entries.
// Head data reads as zero while empty.
module chg_log_fifo #(
  parameter  int W     = 3,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
    end
  end

  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = level_q;

endmodule

// File: rtl/chg_log_monitor.sv
// Value-change monitor: logs {ts, sample} on change or monitor-on.
// CHG_LOG_TIMESTAMP_EN enables the ts counter and out_ts port.
module chg_log_monitor
  import chg_log_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 8,
  parameter  int TS_W  = 32,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WIDTH-1:0]      sample,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
`ifdef CHG_LOG_TIMESTAMP_EN
  output logic [TS_W-1:0]       out_ts,
`endif
  output logic [LW-1:0]         level,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1)
  begin : g_bad_param
    $error("chg_log_monitor: bad DEPTH or TS_W");
  end

`ifdef CHG_LOG_TIMESTAMP_EN
  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic [WIDTH-1:0] data;
  } entry_t;
`endif

  logic [WIDTH-1:0]      prev_q;
  logic                  en_q, prime_q;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ev, push, pop;
  logic                  full, empty;
  entry_t                wr_e, rd_e;

  assign ev   = en && (prime_q || !en_q || sample != prev_q);
  assign pop  = out_valid && out_ready;
  assign push = ev && (!full || pop);

  always_comb begin
    drop_d = drop_q;
    if (ev && !push) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      en_q    <= 1'b0;
      prime_q <= 1'b1;
      drop_q  <= '0;
    end else begin
      prev_q  <= sample;
      en_q    <= en;
      prime_q <= 1'b0;
      drop_q  <= drop_d;
    end
  end

`ifdef CHG_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end

  assign wr_e.ts = ts_q;
  assign out_ts  = rd_e.ts;
`endif

  assign wr_e.data = sample;

  chg_log_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (wr_e),
    .dout_o  (rd_e),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_valid = !empty;
  assign out_data  = rd_e.data;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_chg_log_monitor.sv
// Directed bench for chg_log_monitor (WIDTH=3, DEPTH=8).
// Timestamp checks apply when CHG_LOG_TIMESTAMP_EN is defined.
module tb_chg_log_monitor;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int TS_W  = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] sample;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [LW-1:0]    level;
  logic [15:0]      drop_cnt;
`ifdef CHG_LOG_TIMESTAMP_EN
  logic [TS_W-1:0]  out_ts;
`endif

  int checks = 0;
  int errors = 0;

  chg_log_monitor #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sample    (sample),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef CHG_LOG_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .level     (level),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] s;
    logic       rdy;
    logic       v;
    logic [2:0] d;
    int         lvl;
    int         drop;
    int         ts;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] s, input logic r);
    en        = e;
    sample    = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ts(input string name, input int exp);
`ifdef CHG_LOG_TIMESTAMP_EN
    chk(name, int'(out_ts), exp);
`endif
  endtask

  int exp_q[8];

  initial begin
    // en, s, rdy | valid, data, level, drop, ts (-1 = skip)
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 1, 0, 0};
    tbl[1]  = '{1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 1, 0, 0};
    tbl[2]  = '{1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 0, 0, -1};
    tbl[3]  = '{1'b1, 3'b011, 1'b1, 1'b1, 3'b011, 1, 0, 3};
    tbl[4]  = '{1'b1, 3'b101, 1'b1, 1'b1, 3'b101, 1, 0, 4};
    tbl[5]  = '{1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 1, 0, 5};
    tbl[6]  = '{1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 0, 0, -1};
    tbl[7]  = '{1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 0, 0, -1};
    tbl[8]  = '{1'b0, 3'b100, 1'b1, 1'b0, 3'b000, 0, 0, -1};
    tbl[9]  = '{1'b0, 3'b110, 1'b1, 1'b0, 3'b000, 0, 0, -1};
    tbl[10] = '{1'b1, 3'b110, 1'b0, 1'b1, 3'b110, 1, 0, 10};
    tbl[11] = '{1'b1, 3'b110, 1'b1, 1'b0, 3'b000, 0, 0, -1};

    rst = 1'b1;
    en = 1'b1;
    sample = 3'b000;
    out_ready = 1'b0;
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk_ts("rst_ts", 0);
    #9 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].en, tbl[i].s, tbl[i].rdy);
      chk($sformatf("v%0d_valid", i), int'(out_valid), int'(tbl[i].v));
      chk($sformatf("v%0d_data", i), int'(out_data), int'(tbl[i].d));
      chk($sformatf("v%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("v%0d_drop", i), int'(drop_cnt), tbl[i].drop);
      if (tbl[i].ts >= 0) chk_ts($sformatf("v%0d_ts", i), tbl[i].ts);
    end

    // overflow: DEPTH+3 changes with consumer stalled
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b1, 3'(i % 8), 1'b0);
    end
    chk("ovf_level", int'(level), DEPTH);
    chk("ovf_drop", int'(drop_cnt), 3);
    chk("ovf_head", int'(out_data), 0);

    // full with simultaneous pop and change
    step(1'b1, 3'b101, 1'b1);
    chk("full_pp_level", int'(level), DEPTH);
    chk("full_pp_drop", int'(drop_cnt), 3);
    chk("full_pp_head", int'(out_data), 1);

    exp_q = '{1, 2, 3, 4, 5, 6, 7, 5};
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("drain%0d_data", k), int'(out_data), exp_q[k]);
      step(1'b0, 3'b101, 1'b1);
    end
    chk("drain_level", int'(level), 0);
    chk("drain_valid", int'(out_valid), 0);

    // queue 5 entries then reset asynchronously
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b011, 1'b0);
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b101, 1'b0);
    chk("pre_rst_level", int'(level), 5);
    chk("pre_rst_head", int'(out_data), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    chk_ts("mid_rst_ts", 0);
    en = 1'b1;
    sample = 3'b000;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 3'b000, 1'b0);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_data", int'(out_data), 0);
    chk("post_rst_level", int'(level), 1);
    chk_ts("post_rst_ts", 0);
    step(1'b1, 3'b000, 1'b0);
    chk("post_rst_stable", int'(level), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chg_log_monitor.md
# chg_log_monitor

Synthesizable hardware counterpart of the simulator's value-change monitor: it watches a sampled signal bus every clock and records an entry (timestamp + values) whenever the bus changes. It also records an entry when monitoring is switched on. Entries are buffered in a small FIFO and drained over a valid/ready port. It sits directly downstream of the unit under observation (e.g. the OR-gate stage, whose inputs and output form `sample`), and consumes what that stage produces.

## Interface
Parameters:
- `WIDTH`, 3, width of the observed bus (default a, b, c)
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `TS_W`, 32, timestamp counter width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset; applies to all state
- `en`  in  1  monitor on (1) / off (0); the `$monitoron`/`$monitoroff` equivalent
- `sample`  in  WIDTH  observed signals, sampled each rising edge
- `out_valid`  out  1  FIFO head entry available
- `out_ready`  in  1  consumer accepts head entry
- `out_data`  out  WIDTH  logged sample value of head entry
- `out_ts`  out  TS_W  logged timestamp of head entry (only with `CHG_LOG_TIMESTAMP_EN`)
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `drop_cnt`  out  16  entries lost to overflow, saturating

## Operation
- `ts` is a free-running counter: 0 after reset, +1 every cycle, wraps modulo 2^TS_W.
- `prev` is registered from `sample` every cycle, regardless of `en`.
- `en_q` is registered from `en`.
- Log event at an edge, evaluated only when `en`=1. It fires if either condition holds:
  - `prime`: this is the first edge after reset, or `en_q`=0, i.e. the first edge with the monitor on.
  - `sample != prev`.
- At most one log event per cycle.
- Entry = {`ts`, `sample`}, using the values present at that edge.
- Push when a log event fires and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the event is dropped and `drop_cnt` increments, saturating at 16'hFFFF.
- Pop on `out_valid && out_ready`.
- The FIFO is first-word-fall-through: `out_valid` = (`level` != 0).
- `out_data`/`out_ts` stay stable while `out_valid && !out_ready`.
- Simultaneous push+pop: `level` is unchanged, and order is preserved.
- Pointers wrap modulo DEPTH. Full/empty are derived from `level`.
- With `en`=0 no entries are added, but the FIFO continues to drain.
- Dropping `en` mid-stream keeps already queued entries.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ts`=0, `level`=0, `drop_cnt`=0
  - `ts`=0, `prev`=0, `en_q`=0, prime pending=1
- Latency: an event sampled at edge N appears at the FIFO head with `out_valid`=1 after edge N when the FIFO was empty. It is visible in the same cycle that follows edge N.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation: everything returns to reset values asynchronously, and queued entries are discarded. The first enabled edge after release logs a prime entry.
- Only the value at the rising edge matters. Glitches between edges are not observed.

## Configuration
- `CHG_LOG_TIMESTAMP_EN` defined: `out_ts` port exists, the `ts` counter is instantiated, and the FIFO stores TS_W+WIDTH bits per entry.
- Not defined:
  - `out_ts` port, `ts` counter and timestamp storage are absent.
  - FIFO stores WIDTH bits per entry.
  - All other behaviour is identical.

## Structure
- Package `chg_log_pkg`:
  - entry typedef (struct of ts and data; data-only variant when the macro is off)
  - `DROP_CNT_W` = 16
  - saturation constant
- Sub-module `chg_log_fifo`: synchronous FWFT FIFO, parameterised by entry width and DEPTH, with push/pop/level.
- The top level holds `ts`, `prev`, `en_q`, the prime flag, event detection and `drop_cnt`.

## Test plan
- Reset release with `en`=1 and `sample`=3'b000 → one prime entry with data 000 and `ts`=0. No further entries while `sample` is stable.
- Sequence a,b = 00,01,10,11 one per cycle, c = a|b, so `sample` = 000, 011, 101, 111 → four entries in order. `ts` is consecutive, and `out_valid` rises one edge after each change.
- Hold `out_ready`=0 with a change every cycle for DEPTH+3 cycles:
  - `level`=DEPTH, `drop_cnt`=3.
  - Drain then returns the first DEPTH values in order.
- Full FIFO with `out_ready`=1 and a change in the same cycle → push+pop accepted, `level` stays DEPTH, `drop_cnt` unchanged.
- Sequence `en` 1→0, toggle `sample` three times, then `en` 0→1 → no entries while off. Exactly one prime entry holding the current sample at the re-enable edge.
- Assert `rst` with 5 entries queued → `out_valid`=0, `level`=0 and `drop_cnt`=0 immediately. The `ts` counter restarts at 0.
